// File: rtl/mem_initiator.sv
// Burst master for a valid/ready single-port memory: one request per word, read data streamed out.
// Build with MEM_INIT_CHECK_EN defined to count read words that differ from seed+k.
module mem_initiator #(
  parameter int ADDR_WIDTH = 6,
  parameter int WIDTH      = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  cmd_wr_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [ADDR_WIDTH:0]   cmd_len_i,
  input  logic [WIDTH-1:0]      cmd_seed_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  rd_valid_o,
  output logic                  mem_valid_o,
  output logic                  mem_wr_rd_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0]      mem_wdata_o,
  input  logic [WIDTH-1:0]      mem_rdata_i,
  input  logic                  mem_ready_i,
  output logic [15:0]           mismatch_cnt_o
);

  typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;

  state_t                state_q, state_d;
  logic                  cmd_wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   idx_q;
  logic [WIDTH-1:0]      seed_q;
  logic [7:0]            wait_q;
  logic                  err_q;
  logic                  rd_valid_q;
  logic [WIDTH-1:0]      rd_data_q;

  logic             accept;
  logic             xfer;
  logic             timeout;
  logic [WIDTH-1:0] exp_data;

  assign accept   = (state_q == IDLE) && start_i;
  assign xfer     = (state_q == REQ) && mem_ready_i;
  assign timeout  = (wait_q == 8'(TIMEOUT - 1));
  assign exp_data = seed_q + WIDTH'(idx_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_i) state_d = (cmd_len_i == '0) ? DONE : REQ;
      REQ: begin
        if (mem_ready_i)  state_d = GAP;
        else if (timeout) state_d = DONE;
      end
      // Ready is registered by the responder, so it must be seen low before re-requesting.
      GAP: begin
        if (!mem_ready_i) state_d = (idx_q < len_q) ? REQ : DONE;
        else if (timeout) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cmd_wr_q   <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      seed_q     <= '0;
      wait_q     <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cmd_wr_q <= cmd_wr_i;
        addr_q   <= cmd_addr_i;
        len_q    <= cmd_len_i;
        seed_q   <= cmd_seed_i;
        idx_q    <= '0;
        err_q    <= 1'b0;
      end else if (xfer) begin
        idx_q <= idx_q + 1'b1;
      end
      if (state_d != state_q)
        wait_q <= '0;
      else if (state_q == REQ || state_q == GAP)
        wait_q <= wait_q + 8'd1;
      if (timeout && ((state_q == REQ && !mem_ready_i) || (state_q == GAP && mem_ready_i)))
        err_q <= 1'b1;
      rd_valid_q <= xfer && !cmd_wr_q;
      if (xfer && !cmd_wr_q)
        rd_data_q <= mem_rdata_i;
    end
  end

`ifdef MEM_INIT_CHECK_EN
  logic [15:0] mismatch_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)
      mismatch_q <= '0;
    else if (accept)
      mismatch_q <= '0;
    else if (xfer && !cmd_wr_q && (mem_rdata_i != exp_data) && (mismatch_q != 16'hFFFF))
      mismatch_q <= mismatch_q + 16'd1;
  end

  assign mismatch_cnt_o = mismatch_q;
`else
  assign mismatch_cnt_o = 16'h0000;
`endif

  assign busy_o      = (state_q == REQ) || (state_q == GAP);
  assign done_o      = (state_q == DONE);
  assign err_o       = err_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_data_q;
  assign mem_valid_o = (state_q == REQ);
  assign mem_wr_rd_o = (state_q == REQ) && cmd_wr_q;
  assign mem_addr_o  = (state_q == REQ) ? addr_q + idx_q[ADDR_WIDTH-1:0] : '0;
  assign mem_wdata_o = (state_q == REQ) ? exp_data : '0;

endmodule

// File: tb/tb_mem_initiator.sv
// Randomized bench for mem_initiator: bench-owned responder memory plus a burst-level reference model.
module tb_mem_initiator;
  localparam int AW = 6;
  localparam int W  = 16;
  localparam int TO = 15;
  localparam int D  = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [AW:0]   cmd_len;
  logic [W-1:0]  cmd_seed;
  logic          busy, done, err, rd_valid, mem_valid, mem_wr_rd, mem_ready;
  logic [W-1:0]  rd_data, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mismatch_cnt;

  mem_initiator #(.ADDR_WIDTH(AW), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .cmd_wr_i(cmd_wr), .cmd_addr_i(cmd_addr),
    .cmd_len_i(cmd_len), .cmd_seed_i(cmd_seed), .busy_o(busy), .done_o(done), .err_o(err),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid), .mem_valid_o(mem_valid), .mem_wr_rd_o(mem_wr_rd),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .mem_ready_i(mem_ready), .mismatch_cnt_o(mismatch_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Responder: ready registered one cycle after valid plus a random delay; never ready when stuck.
  logic [W-1:0] resp_mem [D];
  logic         resp_rdy;
  logic [W-1:0] resp_rdata;
  int           resp_wait = 0;
  int           resp_delay = 0;
  bit           stuck = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      resp_rdy  <= 1'b0;
      resp_wait <= 0;
      if (resp_mem[0] === 'x)
        for (int i = 0; i < D; i++) resp_mem[i] <= '0;
    end else if (mem_valid && !resp_rdy && !stuck) begin
      if (resp_wait >= resp_delay) begin
        resp_rdy   <= 1'b1;
        resp_wait  <= 0;
        resp_delay <= $urandom_range(0, 3);
        if (mem_wr_rd) resp_mem[mem_addr] <= mem_wdata;
        else           resp_rdata <= resp_mem[mem_addr];
      end else begin
        resp_wait <= resp_wait + 1;
      end
    end else begin
      resp_rdy <= 1'b0;
    end
  end
  assign mem_ready = resp_rdy;
  assign mem_rdata = resp_rdata;

  // Burst-level reference model.
  logic [W-1:0] shadow [D];
  bit           cur_wr;
  int           cur_addr, cur_len;
  logic [W-1:0] cur_seed;
  int           xfer_idx, done_cnt, valid_cycles;
  bit           prev_hs;
  logic [W-1:0] exp_rd [$];
  logic [W-1:0] rd_log [$];

  always @(negedge clk) begin
    if (rst) begin
      prev_hs = 1'b0;
    end else begin
      if (prev_hs) chk("gap_after_handshake", mem_valid, 0);
      if (mem_valid) begin
        valid_cycles++;
        chk("busy_when_valid", busy, 1);
        chk("mem_addr", mem_addr, (cur_addr + xfer_idx) % D);
        chk("mem_wr_rd", mem_wr_rd, cur_wr);
        chk("mem_wdata", mem_wdata, W'(cur_seed + W'(xfer_idx)));
        chk("xfer_in_range", xfer_idx < cur_len, 1);
        if (mem_ready) xfer_idx++;
      end
      prev_hs = mem_valid && mem_ready;
      if (rd_valid) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rd_data", rd_data, exp_rd.pop_front());
        rd_log.push_back(rd_data);
      end
      if (done) done_cnt++;
    end
  end

  task automatic run_cmd(input bit wr, input int a, input int len, input logic [W-1:0] seed,
                         input bit hold);
    int cyc;
    int exp_mm;
    int diff;
    exp_mm = 0;
    stuck  = hold;
    @(posedge clk); #1;
    cur_wr = wr; cur_addr = a; cur_len = len; cur_seed = seed;
    xfer_idx = 0; done_cnt = 0; valid_cycles = 0;
    rd_log.delete();
    exp_rd.delete();
    if (!hold) begin
      for (int k = 0; k < len; k++) begin
        if (wr) shadow[(a + k) % D] = W'(seed + W'(k));
        else begin
          exp_rd.push_back(shadow[(a + k) % D]);
          if (shadow[(a + k) % D] != W'(seed + W'(k))) exp_mm++;
        end
      end
    end
    start = 1'b1; cmd_wr = wr; cmd_addr = AW'(a); cmd_len = (AW + 1)'(len); cmd_seed = seed;
    cyc = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) chk("err_cleared_on_start", err, 0);
      if (done) break;
      chk("busy_during_burst", busy, 1);
      if (cyc > 3000) begin
        chk("burst_timeout", 0, 1);
        break;
      end
      // Command inputs are junk while busy and must be ignored.
      start = 1'($urandom_range(0, 1)); cmd_wr = 1'($urandom);
      cmd_addr = AW'($urandom); cmd_len = (AW + 1)'($urandom); cmd_seed = W'($urandom);
    end
    start = 1'b0;
    chk("busy_at_done", busy, 0);
    chk("err_at_done", err, hold);
    chk("xfer_count", xfer_idx, hold ? 0 : len);
    chk("rd_remaining", exp_rd.size(), 0);
`ifdef MEM_INIT_CHECK_EN
    chk("mismatch_cnt", mismatch_cnt, exp_mm);
`else
    chk("mismatch_cnt", mismatch_cnt, 0);
`endif
    diff = 0;
    for (int i = 0; i < D; i++) if (resp_mem[i] != shadow[i]) diff++;
    chk("mem_contents", diff, 0);
    if (len == 0) begin
      chk("len0_done_latency", cyc, 1);
      chk("len0_no_valid", valid_cycles, 0);
    end
    if (hold) chk("timeout_valid_cycles", valid_cycles, TO);
    @(posedge clk); #1;
    chk("done_one_pulse", done_cnt, 1);
    chk("done_low_after", done, 0);
    stuck = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_seed = '0;
    for (int i = 0; i < D; i++) shadow[i] = '0;
    cur_len = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {busy, done, err, rd_valid, rd_data, mem_valid, mem_wr_rd, mem_addr,
                          mem_wdata, mismatch_cnt}, 0);
    rst = 1'b0;

    run_cmd(1'b1, 0, 4, 16'h1000, 1'b0);
    chk("t1_mem0", resp_mem[0], 16'h1000);
    chk("t1_mem3", resp_mem[3], 16'h1003);

    run_cmd(1'b0, 0, 4, 16'h1000, 1'b0);
    chk("t2_rd_count", rd_log.size(), 4);
    for (int k = 0; k < 4 && k < rd_log.size(); k++)
      chk("t2_rd_word", rd_log[k], 16'h1000 + k);

    run_cmd(1'b1, 62, 4, 16'hFFFE, 1'b0);
    chk("t3_mem62", resp_mem[62], 16'hFFFE);
    chk("t3_mem63", resp_mem[63], 16'hFFFF);
    chk("t3_mem0", resp_mem[0], 16'h0000);
    chk("t3_mem1", resp_mem[1], 16'h0001);

    run_cmd(1'b0, 5, 6, 16'h0000, 1'b1);
    run_cmd(1'b1, 10, 3, 16'h2222, 1'b0);

    run_cmd(1'b1, 20, 0, 16'h3333, 1'b0);

    run_cmd(1'b1, 0, 64, 16'hABCD, 1'b0);
    run_cmd(1'b0, 0, 64, 16'hABCD, 1'b0);
    run_cmd(1'b0, 7, 9, 16'h5555, 1'b0);

    // Reset on the third word of an eight-word write.
    @(posedge clk); #1;
    cur_wr = 1'b1; cur_addr = 30; cur_len = 8; cur_seed = 16'h7000;
    xfer_idx = 0; done_cnt = 0;
    start = 1'b1; cmd_wr = 1'b1; cmd_addr = AW'(30); cmd_len = 7'd8; cmd_seed = 16'h7000;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (xfer_idx == 2 && mem_valid) break;
      @(posedge clk); #1;
    end
    chk("t6_reached_word3", xfer_idx, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_outputs_after_reset", {busy, done, err, rd_valid, rd_data, mem_valid, mem_wr_rd,
                                   mem_addr, mem_wdata, mismatch_cnt}, 0);
    rst = 1'b0;
    done_cnt = 0;
    repeat (6) @(posedge clk);
    #1;
    chk("t6_no_done", done_cnt, 0);
    chk("t6_idle", busy, 0);
    for (int i = 0; i < D; i++) shadow[i] = resp_mem[i];

    for (int n = 0; n < 30; n++) begin
      int len;
      len = ($urandom_range(0, 5) == 0) ? 64 : $urandom_range(0, 20);
      run_cmd(1'($urandom), $urandom_range(0, D - 1), len, W'($urandom), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
